jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit bank of JK flip-flops between NUM_REQ requesters.
- Each requester submits a per-bit JK command (j, k vectors) plus a repeat count.
- The block grants one command at a time and applies it to the bank for cnt+1 consecutive clock edges. It then reports completion and rotates priority.
- It sits between command sources, such as software-visible control or test sequencers, and the shared JK state register.

Parameters:
- W, 4, width of the JK bank (q) and of each j/k command vector
- NUM_REQ, 2, number of requesters (>= 2)
- CNT_W, 3, width of the repeat-count field; a command performs cnt+1 JK operations

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_j  input  NUM_REQ*W  J vectors, requester r at bits [r*W +: W]
- req_k  input  NUM_REQ*W  K vectors, same packing
- req_cnt  input  NUM_REQ*CNT_W  repeat counts, requester r at [r*CNT_W +: CNT_W]
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational, IDLE only
- q  output  W  current JK bank state
- busy  output  1  high while a command is being applied
- done  output  1  one-cycle pulse after the last JK operation of a command
- done_id  output  $clog2(NUM_REQ)  requester index of the completed command

Behaviour:
- Reset, asynchronous and effective immediately:
  - q=0, state=IDLE, rr_ptr=0, remaining=0, busy=0, done=0, done_id=0.
  - req_ready=0 while reset is high.
- Per-bit JK rule for each applied operation: 00 hold, 01 clear, 10 set, 11 toggle.
- FSM states: IDLE, BUSY.
- IDLE:
  - Grant goes to the first requester with valid=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally; all other ready bits are 0.
  - No valid requests means all-zero ready.
- Accept: at a posedge in IDLE with valid&ready, latch j, k, cnt and the grant index. Set remaining=cnt, go to BUSY, busy=1. q is unchanged on the accept edge.
- BUSY, each posedge:
  - Apply the latched JK op to q.
  - If remaining==0: go to IDLE; done=1 and done_id=grant for the following cycle; rr_ptr=(grant+1) mod NUM_REQ.
  - Otherwise remaining decrements.
- Latency: ops land on edges T+1..T+1+cnt after accept edge T. busy is high for cnt+1 cycles; done is high in the cycle after the last op edge.
- done is a registered single-cycle pulse and is cleared on every other edge.
- req_ready is 0 throughout BUSY. Requesters hold valid until accepted.
- The arbiter re-evaluates every IDLE cycle, so dropping valid before accept is tolerated.
- Throughput: minimum one IDLE cycle between commands (accept in IDLE only).
- cnt = 2^CNT_W-1 gives 2^CNT_W ops. remaining must not wrap or underflow.
- Reset mid-BUSY aborts: q=0, no done pulse, rr_ptr=0.
- Simultaneous valids are resolved only by rr_ptr. With all requesters continuously valid, grants rotate strictly.

Decomposition:
- Shared package jk_pkg contains:
  - JK op constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11
  - the FSM state enum (IDLE, BUSY)
- Sub-module jk_bank:
  - W-bit JK register with an apply-enable input
  - asynchronous active-high reset to 0
  - per-bit JK rule as above
- The arbiter contains the FSM, round-robin pointer, command latch and counter, and instantiates jk_bank.

Test Plan (W=4, NUM_REQ=2, CNT_W=3):
1. Assert reset while clk is idle -> q=0000, req_ready=00, busy=0, done=0 without any clock edge.
2. req0 j=1010 k=0000 cnt=0 -> req_ready=01; q=1010 one edge after accept; busy high 1 cycle; done=1, done_id=0 next cycle.
3. q=1010, req1 j=1111 k=1111 cnt=2 -> q sequence 0101, 1010, 0101 on three edges; busy 3 cycles; done_id=1.
4. req0 and req1 both held valid with distinct cnt=0 commands from rr_ptr=0 -> grants 0,1,0,1. Each done precedes the next accept, with at least one IDLE cycle between.
5. req0 cnt=7 toggle-all, reset asserted after 3 ops -> q=0000 immediately, busy=0, no done pulse. After release, req1 valid gets ready only per rr_ptr=0 search.
6. q=0101, req0 j=1100 k=0110 cnt=0 -> q=1001 (bit3 set, bit2 toggle, bit1 clear, bit0 hold).

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter.
// JK op encodings and the arbiter FSM state type.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/jk_bank.sv
// W-bit bank of JK flip-flops with a shared apply enable.
// Each bit follows its own {j,k} op when en is high.
module jk_bank
  import jk_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      for (int i = 0; i < W; i++) begin
        unique case ({j[i], k[i]})
          JK_HOLD: q[i] <= q[i];
          JK_CLR:  q[i] <= 1'b0;
          JK_SET:  q[i] <= 1'b1;
          JK_TGL:  q[i] <= ~q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK bank among requesters.
// A granted command is applied cnt+1 times, then done pulses.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int W       = 4,
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*W-1:0]       req_j,
  input  logic [NUM_REQ*W-1:0]       req_k,
  input  logic [NUM_REQ*CNT_W-1:0]   req_cnt,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [W-1:0]               q,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [SW-1:0]    sum;
  logic             found;
  logic [W-1:0]     cmd_j;
  logic [W-1:0]     cmd_k;
  logic [CNT_W-1:0] remaining;
  logic [IDW-1:0]   next_ptr;

  // Search upward from rr_ptr with wrap for the first valid.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign next_ptr = (cur_id == IDW'(NUM_REQ - 1))
                  ? '0 : cur_id + IDW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cmd_j     <= '0;
      cmd_k     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            cmd_j     <= req_j[gnt_idx*W +: W];
            cmd_k     <= req_k[gnt_idx*W +: W];
            remaining <= req_cnt[gnt_idx*CNT_W +: CNT_W];
            cur_id    <= gnt_idx;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (remaining == '0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            done_id <= cur_id;
            rr_ptr  <= next_ptr;
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  jk_bank #(.W(W)) u_bank (
    .clk   (clk),
    .reset (reset),
    .en    (state == BUSY),
    .j     (cmd_j),
    .k     (cmd_k),
    .q     (q)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: op-count reference model checked
// every cycle, plus directed literal expectations.
module tb_jk_bank_arbiter;

  localparam int W       = 4;
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 3;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*W-1:0]     req_j;
  logic [NUM_REQ*W-1:0]     req_k;
  logic [NUM_REQ*CNT_W-1:0] req_cnt;
  logic [NUM_REQ-1:0]       req_ready;
  logic [W-1:0]             q;
  logic                     busy;
  logic                     done;
  logic [0:0]               done_id;

  jk_bank_arbiter #(.W(W), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_j     (req_j),
    .req_k     (req_k),
    .req_cnt   (req_cnt),
    .req_ready (req_ready),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id)
  );

  logic clk_en;
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference model: a command is a count of pending ops.
  logic [W-1:0] m_q;
  logic [W-1:0] cj, ck;
  int ops_left, ptr, cid;
  logic m_done;
  int m_done_id;
  int g;

  function automatic logic [W-1:0] jk_next(
    input logic [W-1:0] qq, input logic [W-1:0] j,
    input logic [W-1:0] k);
    return (j & ~qq) | (~k & qq);
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] v,
                              input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int m_ready();
    int r;
    if (reset || ops_left != 0) return 0;
    r = pick(req_valid, ptr);
    return (r < 0) ? 0 : (1 << r);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q       <= '0;
      ops_left  <= 0;
      ptr       <= 0;
      cid       <= 0;
      m_done    <= 1'b0;
      m_done_id <= 0;
    end else begin
      m_done <= 1'b0;
      if (ops_left > 0) begin
        m_q      <= jk_next(m_q, cj, ck);
        ops_left <= ops_left - 1;
        if (ops_left == 1) begin
          m_done    <= 1'b1;
          m_done_id <= cid;
          ptr       <= (cid + 1) % NUM_REQ;
        end
      end else begin
        g = pick(req_valid, ptr);
        if (g >= 0) begin
          cj       <= req_j[g*W +: W];
          ck       <= req_k[g*W +: W];
          cid      <= g;
          ops_left <= int'(req_cnt[g*CNT_W +: CNT_W]) + 1;
        end
      end
    end
  end

  logic chk_on = 1'b0;
  logic log_on = 1'b0;
  int   dq[$];

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("q", int'(q), int'(m_q));
      cmp("busy", int'(busy), int'(ops_left != 0));
      cmp("done", int'(done), int'(m_done));
      if (m_done) cmp("done_id", int'(done_id), m_done_id);
      cmp("req_ready", int'(req_ready), m_ready());
      if (log_on && done) dq.push_back(int'(done_id));
    end
  end

  task automatic wait_busy();
    bit seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = busy;
    end
    cmp("accept_timeout", int'(seen), 1);
  endtask

  task automatic set_req(input int r, input logic [W-1:0] j,
                         input logic [W-1:0] k,
                         input logic [CNT_W-1:0] c);
    req_j[r*W +: W]         = j;
    req_k[r*W +: W]         = k;
    req_cnt[r*CNT_W +: CNT_W] = c;
    req_valid[r]            = 1'b1;
  endtask

  initial begin
    clk_en    = 1'b0;
    reset     = 1'b0;
    req_valid = '0;
    req_j     = '0;
    req_k     = '0;
    req_cnt   = '0;

    // 1: reset with no clock edge
    #1 reset = 1'b1;
    #1;
    cmp("rst_q", int'(q), 0);
    cmp("rst_ready", int'(req_ready), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    #8 clk_en = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;

    // 2: req0 set pattern, single op
    @(negedge clk);
    #2 set_req(0, 4'b1010, 4'b0000, 3'd0);
    #1 cmp("t2_ready", int'(req_ready), 1);
    wait_busy();
    cmp("t2_q_accept", int'(q), 0);
    #1 req_valid = '0;
    @(negedge clk);
    #1;
    cmp("t2_q", int'(q), 4'b1010);
    cmp("t2_done", int'(done), 1);
    cmp("t2_done_id", int'(done_id), 0);
    cmp("t2_busy", int'(busy), 0);

    // 3: req1 toggle-all, three ops
    #1 set_req(1, 4'b1111, 4'b1111, 3'd2);
    #1 cmp("t3_ready", int'(req_ready), 2);
    wait_busy();
    #1 req_valid = '0;
    @(negedge clk); #1 cmp("t3_q1", int'(q), 4'b0101);
    cmp("t3_busy1", int'(busy), 1);
    @(negedge clk); #1 cmp("t3_q2", int'(q), 4'b1010);
    cmp("t3_busy2", int'(busy), 1);
    @(negedge clk); #1 cmp("t3_q3", int'(q), 4'b0101);
    cmp("t3_done", int'(done), 1);
    cmp("t3_done_id", int'(done_id), 1);

    // 4: both continuously valid, strict rotation
    @(negedge clk);
    dq.delete();
    log_on = 1'b1;
    #2;
    set_req(0, 4'b1000, 4'b0000, 3'd0);
    set_req(1, 4'b0000, 4'b1000, 3'd0);
    repeat (8) @(negedge clk);
    #2 req_valid = '0;
    log_on = 1'b0;
    cmp("t4_ndone", dq.size(), 4);
    if (dq.size() == 4) begin
      cmp("t4_g0", dq[0], 0);
      cmp("t4_g1", dq[1], 1);
      cmp("t4_g2", dq[2], 0);
      cmp("t4_g3", dq[3], 1);
    end
    cmp("t4_q", int'(q), 4'b0101);

    // 5: long toggle aborted by reset
    @(negedge clk);
    #2 set_req(0, 4'b1111, 4'b1111, 3'd7);
    wait_busy();
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
    #1 cmp("t5_q3ops", int'(q), 4'b1010);
    #1 reset = 1'b1;
    #1;
    cmp("t5_rst_q", int'(q), 0);
    cmp("t5_rst_busy", int'(busy), 0);
    cmp("t5_rst_done", int'(done), 0);
    cmp("t5_rst_ready", int'(req_ready), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #1;
    set_req(0, 4'b0000, 4'b0000, 3'd0);
    set_req(1, 4'b0101, 4'b1010, 3'd0);
    #1 cmp("t5_ready_both", int'(req_ready), 1);
    req_valid = 2'b10;
    #1 cmp("t5_ready_r1", int'(req_ready), 2);
    wait_busy();
    #1 req_valid = '0;
    @(negedge clk);
    #1 cmp("t5_q", int'(q), 4'b0101);

    // 6: mixed per-bit ops
    #1 set_req(0, 4'b1100, 4'b0110, 3'd0);
    wait_busy();
    #1 req_valid = '0;
    @(negedge clk);
    #1;
    cmp("t6_q", int'(q), 4'b1001);
    cmp("t6_done_id", int'(done_id), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
